sample_ring_buffer: RTL and testbench

SAMPLE_RING_BUFFER -- requirements
Module: sample_ring_buffer

---
 rtl/sample_ring_buffer.sv | 102 ++++++++++
 tb/tb_sample_ring_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_ring_buffer.sv
// rtl/sample_ring_buffer.sv - mixer-to-DAC sample FIFO paced by a sample-rate tick, with prime/run control.
// Optional underrun counter enabled by defining SAMPLE_RING_BUFFER_UNDERRUN_CNT_EN.
module sample_ring_buffer #(
  parameter int DEPTH    = 128,
  parameter int TICK_DIV = 521
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [23:0]                i_sample,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [23:0]                o_dac_sample,
  output logic [31:0]                o_stream_data,
  output logic                       o_strobe,
  output logic [$clog2(DEPTH):0]     o_fill,
  output logic                       o_underrun,
  output logic [15:0]                o_underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {PRIME, RUN} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic [TW-1:0] tick_cnt;
  logic [23:0]   mem [DEPTH];

  logic tick;
  logic push;
  logic pop;
  logic underrun_hit;

  assign tick         = (tick_cnt == TW'(TICK_DIV - 1));
  assign o_ready      = (fill != (AW+1)'(DEPTH));
  assign push         = i_valid && o_ready;
  assign pop          = (state == RUN) && tick && (fill != '0);
  assign underrun_hit = (state == RUN) && tick && (fill == '0);

  assign o_fill        = fill;
  assign o_stream_data = {{8{o_dac_sample[23]}}, o_dac_sample};

  // Storage is never cleared; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      state        <= PRIME;
      o_dac_sample <= '0;
      o_strobe     <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
      o_strobe   <= pop;
      o_underrun <= underrun_hit;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + AW'(1);
        o_dac_sample <= mem[rd_ptr];
      end

      case ({push, pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase

      case (state)
        PRIME:   if (fill >= (AW+1)'(DEPTH / 2)) state <= RUN;
        RUN:     if (underrun_hit) state <= PRIME;
        default: state <= PRIME;
      endcase
    end
  end

`ifdef SAMPLE_RING_BUFFER_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_underrun_cnt <= '0;
    end else if (underrun_hit && (o_underrun_cnt != 16'hFFFF)) begin
      o_underrun_cnt <= o_underrun_cnt + 16'd1;
    end
  end
`else
  assign o_underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sample_ring_buffer.sv
// tb/tb_sample_ring_buffer.sv - scoreboard bench for sample_ring_buffer at DEPTH=8, TICK_DIV=4.
module tb_sample_ring_buffer;

  logic        clk;
  logic        reset;
  logic [23:0] i_sample;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] o_dac_sample;
  logic [31:0] o_stream_data;
  logic        o_strobe;
  logic [3:0]  o_fill;
  logic        o_underrun;
  logic [15:0] o_underrun_cnt;

  sample_ring_buffer #(.DEPTH(8), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .i_sample(i_sample), .i_valid(i_valid),
    .o_ready(o_ready), .o_dac_sample(o_dac_sample), .o_stream_data(o_stream_data),
    .o_strobe(o_strobe), .o_fill(o_fill), .o_underrun(o_underrun),
    .o_underrun_cnt(o_underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          strobes = 0;
  int          ur_pulses = 0;
  int          edge_cnt = 0;
  logic [23:0] last_exp = '0;
  logic [23:0] samp_q[$];
  logic [31:0] strm_q[$];

`ifdef SAMPLE_RING_BUFFER_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops are registered on edges where the tick counter wraps, i.e. every 4th edge after reset.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (o_strobe) begin
        strobes++;
        chk("strobe_phase", 32'(edge_cnt % 4), 32'd0);
        if (samp_q.size() == 0) begin
          chk("unexpected_strobe", {8'h0, o_dac_sample}, 32'hDEAD_0000);
        end else begin
          last_exp = samp_q.pop_front();
          chk("dac_sample", {8'h0, o_dac_sample}, {8'h0, last_exp});
          chk("stream_data", o_stream_data, strm_q.pop_front());
        end
      end
      if (o_underrun) begin
        ur_pulses++;
        chk("underrun_phase", 32'(edge_cnt % 4), 32'd0);
        chk("underrun_hold", {8'h0, o_dac_sample}, {8'h0, last_exp});
      end
    end
  end

  task automatic push2(input logic [23:0] s, input logic [31:0] sx);
    int n = 0;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_timeout", {31'h0, o_ready}, 32'd1);
    if (o_ready) begin
      i_valid = 1'b1;
      i_sample = s;
      samp_q.push_back(s);
      strm_q.push_back(sx);
      @(negedge clk);
      i_valid = 1'b0;
    end
  endtask

  task automatic push(input logic [23:0] s);
    push2(s, {{8{s[23]}}, s});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (samp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(samp_q.size()), 32'd0);
  endtask

  task automatic wait_ur(input int want, input int lim);
    int n = 0;
    while (ur_pulses < want && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("underrun_pulses", 32'(ur_pulses), 32'(want));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'h0, o_ready}, 32'd1);
    chk({tag, "_fill"}, {28'h0, o_fill}, 32'd0);
    chk({tag, "_dac"}, {8'h0, o_dac_sample}, 32'd0);
    chk({tag, "_stream"}, o_stream_data, 32'd0);
    chk({tag, "_strobe"}, {31'h0, o_strobe}, 32'd0);
    chk({tag, "_underrun"}, {31'h0, o_underrun}, 32'd0);
    chk({tag, "_cnt"}, {16'h0, o_underrun_cnt}, 32'd0);
  endtask

  initial begin
    bit dropped;
    int base;
    reset = 1'b1;
    i_valid = 1'b0;
    i_sample = '0;
    @(negedge clk);
    chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    // Priming: three samples never play, the fourth starts playback.
    push(24'h111111); push(24'h222222); push(24'h333333);
    idle(12);
    chk("prime_strobes", 32'(strobes), 32'd0);
    chk("prime_fill", {28'h0, o_fill}, 32'd3);
    push(24'h444444);
    wait_drain(40);
    chk("prime_first_pops", 32'(strobes), 32'd4);
    wait_ur(1, 20);
    idle(2);
    chk("ur_cnt_1", {16'h0, o_underrun_cnt}, CNT_EN ? 32'd1 : 32'd0);
    idle(12);
    chk("back_in_prime", 32'(ur_pulses), 32'd1);

    // Sign extension on the stream output.
    push2(24'h800000, 32'hFF800000);
    push2(24'h7FFFFF, 32'h007FFFFF);
    push2(24'h000001, 32'h00000001);
    push2(24'hFFFFFF, 32'hFFFFFFFF);
    wait_drain(40);
    wait_ur(2, 20);

    // Fill to capacity, then offer a value that must be dropped.
    for (int i = 0; i < 12; i++) push(24'h0A0000 + 24'(i));
    dropped = 1'b0;
    for (int k = 0; k < 20 && !dropped; k++) begin
      if (!o_ready) begin
        chk("full_fill", {28'h0, o_fill}, 32'd8);
        i_valid = 1'b1;
        i_sample = 24'h123456;
        @(negedge clk);
        i_valid = 1'b0;
        dropped = 1'b1;
      end else begin
        push(24'h0B0000 + 24'(k));
      end
    end
    chk("full_reached", {31'h0, dropped}, 32'd1);
    wait_drain(100);
    wait_ur(3, 20);

    // Wrap: pointers cross DEPTH-1 several times.
    for (int i = 1; i <= 20; i++) push(24'(i));
    wait_drain(100);
    wait_ur(4, 20);
    chk("ur_cnt_4", {16'h0, o_underrun_cnt}, CNT_EN ? 32'd4 : 32'd0);

    // Reset with five samples buffered; align so no tick pops before the check.
    base = 0;
    while (edge_cnt % 4 != 0 && base < 8) begin
      @(negedge clk);
      base++;
    end
    for (int i = 0; i < 5; i++) push(24'h500000 + 24'(i));
    idle(1);
    chk("pre_reset_fill", {28'h0, o_fill}, 32'd5);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrun");
    samp_q.delete();
    strm_q.delete();
    last_exp = '0;
    @(negedge clk);
    reset = 1'b0;
    base = strobes;
    push(24'h600001); push(24'h600002); push(24'h600003);
    idle(12);
    chk("post_reset_prime_fill", {28'h0, o_fill}, 32'd3);
    chk("post_reset_no_strobe", 32'(strobes), 32'(base));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
